jt6295_chseq: RTL and testbench
===============================

# jt6295_chseq

Four-channel ADPCM address sequencer sitting directly downstream of the phrase-table controller. It accepts per-channel start and stop requests with 18-bit start/stop byte addresses and attenuation. It time-multiplexes one ROM port across the four voices and walks each phrase nibble by nibble. Each slot delivers one tagged 4-bit ADPCM code per active channel to the decoder.

## Interface
- No parameters.
- `rst` in 1: reset, synchronous, active-high.
- `clk` in 1: clock.
- `cen4` in 1: slot enable, four per output sample.
- `cen1` in 1: sample enable; coincides with every 4th `cen4`.
- `start` in 4: per-channel start request; held until acked.
- `stop` in 4: per-channel stop request, level.
- `start_addr` in 18: phrase start byte address, valid while any `start` bit is high.
- `stop_addr` in 18: phrase last byte address.
- `att` in 4: attenuation code for the phrase.
- `busy` out 4: channel playing.
- `ack` out 4: start accepted.
- `zero` out 1: one-clk pulse at the start of slot 0.
- `rom_addr` out 18: ROM byte address.
- `rom_data` in 8: ROM data.
- `rom_ok` in 1: `rom_data` valid for the current `rom_addr`.
- `smp` out 4: ADPCM nibble.
- `smp_ch` out 2: channel of `smp`.
- `smp_att` out 4: attenuation of `smp_ch`.
- `smp_first` out 1: first nibble of a phrase; the decoder resets its predictor on it.
- `smp_vld` out 1: one-clk strobe qualifying the `smp_*` outputs.

## Operation
- Slot counter `sl` (2 bits) increments on each `cen4`. When `cen1` and `cen4` are high together, `sl` is forced to 0.
- Per-channel state:
  - `busy`
  - 19-bit nibble pointer `np`: byte address `np[18:1]`; `np[0]`=0 selects the high nibble.
  - 18-bit `end`
  - 4-bit `att`
  - `first` flag
- **Slot open** (the `cen4` edge where slot s begins), for channel s:
  - If `stop[s]`: clear `busy[s]`. Stop has priority over a simultaneous start.
  - Else if `start[s]` and `!ack[s]` and `!busy[s]`: load `np`={start_addr,0}, `end`=stop_addr, `att`=att, set `first`, set `busy[s]` and `ack[s]`.
  - Else if `start[s]` and `busy[s]`: set `ack[s]` without reloading. The request is dropped.
  - Drive `rom_addr`=`np[s][18:1]`.
- **Ack clearing**: `ack[s]` clears on the first clk where `start[s]`=0.
- **Slot close** (the next `cen4` edge), if `busy[s]` and `rom_ok`:
  - Emit `smp` = `rom_data[7:4]` when `np[0]`=0, else `rom_data[3:0]`.
  - Drive `smp_ch`=s, `smp_att`=`att[s]`, `smp_first`=`first[s]`, and pulse `smp_vld`.
  - Clear `first[s]`.
  - If `np[18:1]`==`end` and `np[0]`=1: clear `busy[s]`. Else `np` += 1.
- **ROM not ready**: if `!rom_ok` at slot close, emit nothing and leave `np` unchanged. The nibble is retried next sample.
- **Idle channel**: produces no `smp_vld`.
- **Pointer wrap**: `np` wraps modulo 2^19 (byte 3FFFF to 00000).
- **Stop mid-phrase**: the close of an already-opened slot still emits its nibble. No further nibbles follow.

## Timing
- Reset values: `busy`=0, `ack`=0, `zero`=0, `rom_addr`=0, `smp`=0, `smp_ch`=0, `smp_att`=0, `smp_first`=0, `smp_vld`=0, `sl`=0. All per-channel state is cleared.
- `rst` mid-phrase aborts every channel within one clk.
- `ack[s]` rises one clk after the slot-open `cen4` edge.
- `busy[s]` rises on the same clk as `ack[s]`.
- `rom_addr` is registered and stable for the whole slot. `rom_ok` may assert any time before slot close.
- `smp_*` outputs update, and `smp_vld` pulses, one clk after the slot-close `cen4`.
- First nibble of a phrase: emitted at the end of the slot it was loaded in.
- Sequencer throughput: one nibble per channel per `cen1` period.
- Phrase length: (end − start + 1) × 2 nibbles.

## Test plan
- **Single phrase**: start=0001, start_addr=00100, stop_addr=00101, ROM[100]=A5, ROM[101]=3C.
  - Ch0 emits A, 5, 3, C on consecutive samples; `smp_first` only on A.
  - `busy[0]` falls after C; exactly one `ack[0]` pulse.
- **Stop priority**: start=0010 and stop=0010 held together → `busy[1]` stays 0, `ack[1]` stays 0. Then drop stop → phrase starts on ch1's next slot.
- **Busy retrigger**: start ch2 while ch2 is busy → `ack[2]` asserts, and the `np`, `end` and `att` of ch2 are unchanged.
- **All four channels, att 0..3**: `smp_ch` cycles 0,1,2,3 per sample with matching `smp_att`. `zero` pulses once per `cen1`.
- **ROM stall**: hold `rom_ok`=0 for one ch0 slot → no `smp_vld` for ch0 that sample. The same nibble is emitted next sample.
- **Wrap and reset**:
  - start_addr=3FFFF, stop_addr=00000 → nibbles from 3FFFF then 00000, then `busy` clears.
  - Assert `rst` mid-phrase → all outputs return to their reset values.

Source files
------------

// File: rtl/jt6295_chseq.sv
`default_nettype none
// ============================================================================
//  Module   : jt6295_chseq
//  Purpose  : Four-channel ADPCM address sequencer. Time-multiplexes one ROM
//             port over four voices and walks each phrase nibble by nibble,
//             delivering one tagged 4-bit code per active channel per sample.
//  Revision : 1.0 - initial release
// ============================================================================
module jt6295_chseq (
    input  logic        rst,
    input  logic        clk,
    input  logic        cen4,
    input  logic        cen1,
    input  logic [3:0]  start,
    input  logic [3:0]  stop,
    input  logic [17:0] start_addr,
    input  logic [17:0] stop_addr,
    input  logic [3:0]  att,
    output logic [3:0]  busy,
    output logic [3:0]  ack,
    output logic        zero,
    output logic [17:0] rom_addr,
    input  logic [7:0]  rom_data,
    input  logic        rom_ok,
    output logic [3:0]  smp,
    output logic [1:0]  smp_ch,
    output logic [3:0]  smp_att,
    output logic        smp_first,
    output logic        smp_vld
);

    // Per-channel phrase state
    logic [18:0] r_np    [0:3];
    logic [17:0] r_end   [0:3];
    logic [3:0]  r_att   [0:3];
    logic [3:0]  r_first;
    logic [3:0]  r_busy;
    logic [3:0]  r_ack;

    // Slot counter and registered outputs
    logic [1:0]  r_sl;
    logic        r_zero;
    logic [17:0] r_rom_addr;
    logic [3:0]  r_smp;
    logic [1:0]  r_smp_ch;
    logic [3:0]  r_smp_att;
    logic        r_smp_first;
    logic        r_smp_vld;

    // On a cen4 edge the current slot closes and the next one opens
    logic [1:0]  w_open_ch;
    logic [1:0]  w_close_ch;
    logic [18:0] w_np_cls;
    logic [18:0] w_np_inc;
    logic        w_close_fire;
    logic        w_close_last;
    logic        w_same_ch;
    logic [3:0]  w_nib;
    logic [17:0] w_open_byte;
    logic        w_load;
    logic [3:0]  w_busy_nx;
    logic [3:0]  w_ack_nx;

    assign w_close_ch   = r_sl;
    assign w_open_ch    = cen1 ? 2'd0 : r_sl + 2'd1;
    assign w_np_cls     = r_np[w_close_ch];
    assign w_np_inc     = w_np_cls + 19'd1;   // wraps modulo 2^19
    assign w_close_fire = cen4 & r_busy[w_close_ch] & rom_ok;
    assign w_close_last = (w_np_cls[18:1] == r_end[w_close_ch]) & w_np_cls[0];
    assign w_nib        = w_np_cls[0] ? rom_data[3:0] : rom_data[7:4];
    assign w_same_ch    = (w_open_ch == w_close_ch);

    // If the closing and opening slot are the same channel (cen1 landing on
    // slot 0), the opening address must see the pointer the close just advanced.
    assign w_open_byte  = (w_close_fire & w_same_ch & ~w_close_last) ?
                          w_np_inc[18:1] : r_np[w_open_ch][18:1];

    // Busy/ack next state: slot close first, then slot open decisions
    always_comb begin
        w_busy_nx = r_busy;
        w_ack_nx  = r_ack & start;
        w_load    = 1'b0;
        if (w_close_fire && w_close_last) begin
            w_busy_nx[w_close_ch] = 1'b0;
        end
        if (cen4) begin
            if (stop[w_open_ch]) begin
                w_busy_nx[w_open_ch] = 1'b0;
            end else if (start[w_open_ch] && !r_ack[w_open_ch] && !w_busy_nx[w_open_ch]) begin
                w_load                = 1'b1;
                w_busy_nx[w_open_ch]  = 1'b1;
                w_ack_nx[w_open_ch]   = 1'b1;
            end else if (start[w_open_ch] && w_busy_nx[w_open_ch]) begin
                // Retrigger of a playing channel is acknowledged but ignored
                w_ack_nx[w_open_ch]   = 1'b1;
            end
        end
    end

    // Per-channel state: pointer advance on close, phrase load on open
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy  <= 4'd0;
            r_ack   <= 4'd0;
            r_first <= 4'd0;
            for (int i = 0; i < 4; i++) begin
                r_np[i]  <= 19'd0;
                r_end[i] <= 18'd0;
                r_att[i] <= 4'd0;
            end
        end else begin
            r_busy <= w_busy_nx;
            r_ack  <= w_ack_nx;
            if (w_close_fire) begin
                r_first[w_close_ch] <= 1'b0;
                if (!w_close_last) begin
                    r_np[w_close_ch] <= w_np_inc;
                end
            end
            if (w_load) begin
                r_np[w_open_ch]    <= {start_addr, 1'b0};
                r_end[w_open_ch]   <= stop_addr;
                r_att[w_open_ch]   <= att;
                r_first[w_open_ch] <= 1'b1;
            end
        end
    end

    // Slot counter, ROM address, sample strobe and decoder-facing outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sl        <= 2'd0;
            r_zero      <= 1'b0;
            r_rom_addr  <= 18'd0;
            r_smp       <= 4'd0;
            r_smp_ch    <= 2'd0;
            r_smp_att   <= 4'd0;
            r_smp_first <= 1'b0;
            r_smp_vld   <= 1'b0;
        end else begin
            r_zero    <= cen4 & cen1;
            r_smp_vld <= w_close_fire;
            if (cen4) begin
                r_sl       <= w_open_ch;
                r_rom_addr <= w_load ? start_addr : w_open_byte;
            end
            if (w_close_fire) begin
                r_smp       <= w_nib;
                r_smp_ch    <= w_close_ch;
                r_smp_att   <= r_att[w_close_ch];
                r_smp_first <= r_first[w_close_ch];
            end
        end
    end

    assign busy      = r_busy;
    assign ack       = r_ack;
    assign zero      = r_zero;
    assign rom_addr  = r_rom_addr;
    assign smp       = r_smp;
    assign smp_ch    = r_smp_ch;
    assign smp_att   = r_smp_att;
    assign smp_first = r_smp_first;
    assign smp_vld   = r_smp_vld;

endmodule
`default_nettype wire

// File: tb/tb_jt6295_chseq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jt6295_chseq
//  Purpose  : Self-checking bench for jt6295_chseq, scoreboard style.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_jt6295_chseq;

    logic        clk;
    logic        rst;
    logic        cen4;
    logic        cen1;
    logic [3:0]  start;
    logic [3:0]  stop;
    logic [17:0] start_addr;
    logic [17:0] stop_addr;
    logic [3:0]  att;
    logic [3:0]  busy;
    logic [3:0]  ack;
    logic        zero;
    logic [17:0] rom_addr;
    logic [7:0]  rom_data;
    logic        rom_ok;
    logic [3:0]  smp;
    logic [1:0]  smp_ch;
    logic [3:0]  smp_att;
    logic        smp_first;
    logic        smp_vld;

    logic [3:0]  cnt;
    logic        stall_arm;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [1:0] ch;
        logic [3:0] nib;
        logic [3:0] att;
        logic       first;
    } exp_t;

    exp_t exp_q[$];

    int          vld_cnt [4];
    int          zero_cnt;
    int          ack0_rises;
    logic        ack0_prev;
    logic        ord_en;
    logic        ord_have;
    logic [1:0]  ord_last;

    jt6295_chseq dut (
        .rst        (rst),
        .clk        (clk),
        .cen4       (cen4),
        .cen1       (cen1),
        .start      (start),
        .stop       (stop),
        .start_addr (start_addr),
        .stop_addr  (stop_addr),
        .att        (att),
        .busy       (busy),
        .ack        (ack),
        .zero       (zero),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .rom_ok     (rom_ok),
        .smp        (smp),
        .smp_ch     (smp_ch),
        .smp_att    (smp_att),
        .smp_first  (smp_first),
        .smp_vld    (smp_vld)
    );

    // Directed ROM contents
    function automatic logic [7:0] rom_f(input logic [17:0] a);
        case (a)
            18'h00100: return 8'hA5;
            18'h00101: return 8'h3C;
            18'h00200: return 8'h7E;
            18'h00300: return 8'h12;
            18'h00301: return 8'h34;
            18'h00302: return 8'h56;
            18'h00303: return 8'h78;
            18'h00400: return 8'h19;
            18'h00401: return 8'h2A;
            18'h00402: return 8'h3B;
            18'h00403: return 8'h4C;
            18'h00500: return 8'hB4;
            18'h3FFFF: return 8'hD2;
            18'h00000: return 8'h9F;
            default:   return a[7:0] ^ 8'h5A;
        endcase
    endfunction

    assign rom_data = rom_f(rom_addr);
    assign rom_ok   = !(stall_arm && cnt[3:2] == 2'd0);
    assign cen4     = (cnt[1:0] == 2'd3);
    assign cen1     = (cnt == 4'd15);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Enable generator: four slots of four clocks per sample
    initial begin
        cnt = 4'd0;
        forever begin
            @(posedge clk);
            #1 cnt = cnt + 4'd1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic push(input int ch, input logic [3:0] nib, input logic [3:0] a, input logic f);
        exp_t e;
        e.ch = 2'(ch); e.nib = nib; e.att = a; e.first = f;
        exp_q.push_back(e);
    endtask

    task automatic push_phrase(input int ch, input logic [17:0] sa, input logic [17:0] ea,
                               input logic [3:0] a);
        logic [17:0] n;
        logic [17:0] ad;
        logic [7:0]  b;
        n = ea - sa;
        for (int i = 0; i <= int'(n); i++) begin
            ad = sa + 18'(i);
            b  = rom_f(ad);
            push(ch, b[7:4], a, i == 0);
            push(ch, b[3:0], a, 1'b0);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"},      32'(busy),      0);
        chk({tag, "_ack"},       32'(ack),       0);
        chk({tag, "_zero"},      32'(zero),      0);
        chk({tag, "_rom_addr"},  32'(rom_addr),  0);
        chk({tag, "_smp"},       32'(smp),       0);
        chk({tag, "_smp_ch"},    32'(smp_ch),    0);
        chk({tag, "_smp_att"},   32'(smp_att),   0);
        chk({tag, "_smp_first"}, 32'(smp_first), 0);
        chk({tag, "_smp_vld"},   32'(smp_vld),   0);
    endtask

    // Raise start for one channel, wait for its ack, then release it
    task automatic do_start(input int ch, input logic [17:0] sa, input logic [17:0] ea,
                            input logic [3:0] a);
        int n;
        start_addr = sa;
        stop_addr  = ea;
        att        = a;
        start[ch]  = 1'b1;
        n = 0;
        while (!ack[ch] && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!ack[ch]) begin
            chk($sformatf("ack%0d_timeout", ch), 32'(ack[ch]), 1);
        end else begin
            chk($sformatf("busy%0d_with_ack", ch), 32'(busy[ch]), 1);
        end
        start[ch] = 1'b0;
        @(negedge clk);
        chk($sformatf("ack%0d_clear", ch), 32'(ack[ch]), 0);
    endtask

    task automatic wait_idle(input logic [3:0] m, input string nm);
        int n;
        n = 0;
        while ((busy & m) != 4'd0 && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 32'(busy & m), 0);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: pop the oldest expected entry for the emitting channel
    initial begin
        int idx;
        exp_t e;
        logic [1:0] nxt;
        zero_cnt   = 0;
        ack0_rises = 0;
        ack0_prev  = 1'b0;
        ord_have   = 1'b0;
        ord_last   = 2'd0;
        for (int i = 0; i < 4; i++) vld_cnt[i] = 0;
        forever begin
            @(negedge clk);
            if (zero) zero_cnt++;
            if (ack[0] && !ack0_prev) ack0_rises++;
            ack0_prev = ack[0];
            if (!rst && smp_vld) begin
                vld_cnt[smp_ch]++;
                idx = -1;
                for (int i = 0; i < exp_q.size(); i++) begin
                    if (exp_q[i].ch == smp_ch) begin
                        idx = i;
                        break;
                    end
                end
                checks++;
                if (idx < 0) begin
                    failures++;
                    $display("FAIL unexpected_smp ch%0d: got nib=%h att=%h first=%b, required no sample",
                             smp_ch, smp, smp_att, smp_first);
                end else begin
                    e = exp_q[idx];
                    exp_q.delete(idx);
                    if ({smp, smp_att, smp_first} !== {e.nib, e.att, e.first}) begin
                        failures++;
                        $display("FAIL smp_ch%0d: got nib=%h att=%h first=%b, required nib=%h att=%h first=%b",
                                 smp_ch, smp, smp_att, smp_first, e.nib, e.att, e.first);
                    end
                end
                if (ord_en) begin
                    if (ord_have) begin
                        nxt = ord_last + 2'd1;
                        chk("t4_ch_order", 32'(smp_ch), 32'(nxt));
                    end
                    ord_last = smp_ch;
                    ord_have = 1'b1;
                end
            end
            if (!ord_en) ord_have = 1'b0;
        end
    end

    initial begin
        int v0;
        int n;
        rst        = 1'b1;
        start      = 4'd0;
        stop       = 4'd0;
        start_addr = 18'd0;
        stop_addr  = 18'd0;
        att        = 4'd0;
        stall_arm  = 1'b0;
        ord_en     = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // Single phrase on ch0: A,5,3,C
        ack0_rises = 0;
        push(0, 4'hA, 4'h7, 1'b1);
        push(0, 4'h5, 4'h7, 1'b0);
        push(0, 4'h3, 4'h7, 1'b0);
        push(0, 4'hC, 4'h7, 1'b0);
        do_start(0, 18'h00100, 18'h00101, 4'h7);
        wait_idle(4'b0001, "t1_busy_falls");
        repeat (4) @(negedge clk);
        chk("t1_ack_pulses", 32'(ack0_rises), 1);
        chk("t1_queue_empty", 32'(exp_q.size()), 0);

        // Stop has priority over start on ch1
        start_addr = 18'h00200;
        stop_addr  = 18'h00200;
        att        = 4'h2;
        stop[1]    = 1'b1;
        start[1]   = 1'b1;
        repeat (40) @(negedge clk);
        chk("t2_busy_held_off", 32'(busy[1]), 0);
        chk("t2_ack_held_off", 32'(ack[1]), 0);
        push_phrase(1, 18'h00200, 18'h00200, 4'h2);
        stop[1] = 1'b0;
        do_start(1, 18'h00200, 18'h00200, 4'h2);
        wait_idle(4'b0010, "t2_busy_falls");

        // Retrigger of a busy channel is acked but does not reload
        push_phrase(2, 18'h00300, 18'h00303, 4'h5);
        do_start(2, 18'h00300, 18'h00303, 4'h5);
        repeat (20) @(negedge clk);
        do_start(2, 18'h00010, 18'h00010, 4'h9);
        chk("t3_busy_kept", 32'(busy[2]), 1);
        wait_idle(4'b0100, "t3_busy_falls");

        // All four channels with att 0..3
        for (int c = 0; c < 4; c++) begin
            push_phrase(c, 18'h00400, 18'h00403, 4'(c));
            do_start(c, 18'h00400, 18'h00403, 4'(c));
        end
        chk("t4_all_busy", 32'(busy), 32'hF);
        ord_en   = 1'b1;
        zero_cnt = 0;
        repeat (64) @(negedge clk);
        chk("t4_zero_pulses", 32'(zero_cnt), 4);
        ord_en = 1'b0;
        wait_idle(4'b1111, "t4_busy_falls");

        // ROM stall on ch0's first slot
        push(0, 4'hB, 4'h1, 1'b1);
        push(0, 4'h4, 4'h1, 1'b0);
        do_start(0, 18'h00500, 18'h00500, 4'h1);
        v0 = vld_cnt[0];
        stall_arm = 1'b1;
        n = 0;
        while (cnt != 4'd4 && n < 32) begin
            @(negedge clk);
            n++;
        end
        stall_arm = 1'b0;
        chk("t5_no_vld_when_stalled", 32'(vld_cnt[0] - v0), 0);
        wait_idle(4'b0001, "t5_busy_falls");

        // Pointer wrap 3FFFF -> 00000 on ch3
        push(3, 4'hD, 4'hE, 1'b1);
        push(3, 4'h2, 4'hE, 1'b0);
        push(3, 4'h9, 4'hE, 1'b0);
        push(3, 4'hF, 4'hE, 1'b0);
        do_start(3, 18'h3FFFF, 18'h00000, 4'hE);
        wait_idle(4'b1000, "t6_wrap_busy_falls");

        // Reset in the middle of a long phrase
        push_phrase(1, 18'h00600, 18'h0060F, 4'h3);
        do_start(1, 18'h00600, 18'h0060F, 4'h3);
        repeat (48) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_reset("midrst");
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (64) @(negedge clk);
        chk("post_rst_idle", 32'(busy), 0);
        chk("final_queue_empty", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
